// File: rtl/bru_pkg.sv
// Shared definitions for the branch resolve unit.
//   - funct3 branch-condition encodings
//   - 2-bit saturating counter type and its four states
//   - ctr_update(): saturating increment/decrement of one counter
package bru_pkg;

   // Branch condition encodings (funct3); 3'b010 and 3'b011 are reserved
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef logic [1:0] bht_ctr_t;

   localparam bht_ctr_t SNT = 2'b00;  // strongly not-taken
   localparam bht_ctr_t WNT = 2'b01;  // weakly not-taken (reset state)
   localparam bht_ctr_t WT  = 2'b10;  // weakly taken
   localparam bht_ctr_t ST  = 2'b11;  // strongly taken

   function automatic bht_ctr_t ctr_update(input bht_ctr_t ctr, input logic taken);
      bht_ctr_t nxt;
      nxt = ctr;
      if (taken) begin
         if (ctr != ST) nxt = ctr + 2'd1;
      end else begin
         if (ctr != SNT) nxt = ctr - 2'd1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/bru_bht.sv
// Branch history table: BHT_ENTRIES 2-bit saturating counters.
// Ports:
//   clock, reset_n        clock, async active-low reset (all counters -> WNT)
//   rd_idx / rd_ctr       combinational read port (returns the stored value,
//                         so a same-cycle write is not visible until next cycle)
//   wr_en, wr_idx,        write port: on wr_en the indexed counter moves one
//   wr_taken              step towards taken/not-taken, saturating
module bru_bht
   import bru_pkg::*;
#(
   parameter int unsigned BHT_ENTRIES = 64,
   parameter int unsigned IDX         = $clog2(BHT_ENTRIES)
) (
   input  logic           clock,
   input  logic           reset_n,
   input  logic [IDX-1:0] rd_idx,
   output bht_ctr_t       rd_ctr,
   input  logic           wr_en,
   input  logic [IDX-1:0] wr_idx,
   input  logic           wr_taken
);

   bht_ctr_t ctr_q [BHT_ENTRIES];

   assign rd_ctr = ctr_q[rd_idx];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
            ctr_q[i] <= WNT;
         end
      end else if (wr_en) begin
         ctr_q[wr_idx] <= ctr_update(ctr_q[wr_idx], wr_taken);
      end
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: evaluates a conditional branch, registers the result
// behind a valid/ready handshake (latency 1, full throughput) and trains a
// 2-bit-counter BHT that fetch can query combinationally.
// Ports:
//   clock, reset_n                 clock, async active-low reset
//   in_valid / in_ready            request handshake
//   in_pc, in_rs1, in_rs2,         branch PC, operands, taken target
//   in_target
//   in_funct3, in_pred_taken       branch condition, fetch-time prediction
//   out_valid / out_ready          result handshake
//   out_taken, out_mispredict,     resolved direction, mispredict flag,
//   out_illegal, out_redirect_pc   reserved-funct3 flag, next PC
//   flush                          drops the held result and any same-cycle accept
//   lookup_pc / lookup_taken       combinational BHT prediction read
// Build option: define BRU_STATS_EN to add the stat_branches and
// stat_mispredicts saturating 32-bit counters.
module branch_resolve_unit
   import bru_pkg::*;
#(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned BHT_ENTRIES = 64
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_rs1,
   input  logic [XLEN-1:0] in_rs2,
   input  logic [XLEN-1:0] in_target,
   input  logic [2:0]      in_funct3,
   input  logic            in_pred_taken,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            out_taken,
   output logic            out_mispredict,
   output logic            out_illegal,
   output logic [XLEN-1:0] out_redirect_pc,
   input  logic            flush,
   input  logic [XLEN-1:0] lookup_pc,
   output logic            lookup_taken
`ifdef BRU_STATS_EN
   ,
   output logic [31:0]     stat_branches,
   output logic [31:0]     stat_mispredicts
`endif
);

   localparam int unsigned IDX = $clog2(BHT_ENTRIES);
   localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

   // ---------------------------------------------------------------------
   // Condition evaluation
   // ---------------------------------------------------------------------
   logic            cmp_eq, cmp_lt_s, cmp_lt_u;
   logic            res_taken, res_illegal, res_mispredict;
   logic [XLEN-1:0] res_redirect;

   assign cmp_eq   = (in_rs1 == in_rs2);
   assign cmp_lt_s = ($signed(in_rs1) < $signed(in_rs2));
   assign cmp_lt_u = (in_rs1 < in_rs2);

   always_comb begin
      res_taken   = 1'b0;
      res_illegal = 1'b0;
      case (in_funct3)
         F3_BEQ:  res_taken = cmp_eq;
         F3_BNE:  res_taken = !cmp_eq;
         F3_BLT:  res_taken = cmp_lt_s;
         F3_BGE:  res_taken = !cmp_lt_s;
         F3_BLTU: res_taken = cmp_lt_u;
         F3_BGEU: res_taken = !cmp_lt_u;
         default: res_illegal = 1'b1;
      endcase
   end

   assign res_redirect   = res_taken ? in_target : (in_pc + PC_STEP);
   assign res_mispredict = (res_taken != in_pred_taken) && !res_illegal;

   // ---------------------------------------------------------------------
   // Handshake and output register
   // ---------------------------------------------------------------------
   logic            accept, commit;
   logic            out_valid_q, out_valid_d;
   logic            out_taken_q, out_mispredict_q, out_illegal_q;
   logic [XLEN-1:0] out_redirect_q;

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;
   // flush wins over a same-cycle accept: the request is dropped entirely
   assign commit   = accept && !flush;

   always_comb begin
      out_valid_d = out_valid_q;
      if (flush) begin
         out_valid_d = 1'b0;
      end else if (accept) begin
         out_valid_d = 1'b1;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         out_valid_q      <= 1'b0;
         out_taken_q      <= 1'b0;
         out_mispredict_q <= 1'b0;
         out_illegal_q    <= 1'b0;
         out_redirect_q   <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         if (commit) begin
            out_taken_q      <= res_taken;
            out_mispredict_q <= res_mispredict;
            out_illegal_q    <= res_illegal;
            out_redirect_q   <= res_redirect;
         end
      end
   end

   assign out_valid       = out_valid_q;
   assign out_taken       = out_taken_q;
   assign out_mispredict  = out_mispredict_q;
   assign out_illegal     = out_illegal_q;
   assign out_redirect_pc = out_redirect_q;

   // ---------------------------------------------------------------------
   // Branch history table
   // ---------------------------------------------------------------------
   bht_ctr_t lookup_ctr;
   logic     bht_wr_en;
   logic     unused_lookup_bits;

   assign bht_wr_en = commit && !res_illegal;

   bru_bht #(
      .BHT_ENTRIES (BHT_ENTRIES),
      .IDX         (IDX)
   ) u_bht (
      .clock    (clock),
      .reset_n  (reset_n),
      .rd_idx   (lookup_pc[IDX+1:2]),
      .rd_ctr   (lookup_ctr),
      .wr_en    (bht_wr_en),
      .wr_idx   (in_pc[IDX+1:2]),
      .wr_taken (res_taken)
   );

   assign lookup_taken = lookup_ctr[1];

   // Only the index bits of lookup_pc select an entry
   assign unused_lookup_bits = ^{lookup_pc[XLEN-1:IDX+2], lookup_pc[1:0], lookup_ctr[0]};

`ifdef BRU_STATS_EN
   // ---------------------------------------------------------------------
   // Statistics counters (saturating)
   // ---------------------------------------------------------------------
   logic [31:0] stat_branches_q, stat_mispredicts_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stat_branches_q    <= '0;
         stat_mispredicts_q <= '0;
      end else if (bht_wr_en) begin
         if (stat_branches_q != 32'hFFFF_FFFF) begin
            stat_branches_q <= stat_branches_q + 32'd1;
         end
         if (res_mispredict && (stat_mispredicts_q != 32'hFFFF_FFFF)) begin
            stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
         end
      end
   end

   assign stat_branches    = stat_branches_q;
   assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule
